// File: rtl/noc_pkg.sv
// Shared definitions for the 4x4 mesh: flit field positions, router port
// indices and the small helpers used by route compute and arbitration.
package noc_pkg;

   localparam int FLIT_W   = 64;
   localparam int XDIR_BIT = 62;
   localparam int YDIR_BIT = 61;
   localparam int HOPX_LSB = 52;
   localparam int HOPY_LSB = 48;

   localparam logic [2:0] PORT_L = 3'd0;
   localparam logic [2:0] PORT_N = 3'd1;
   localparam logic [2:0] PORT_S = 3'd2;
   localparam logic [2:0] PORT_E = 3'd3;
   localparam logic [2:0] PORT_W = 3'd4;

   // Dimension-order routing: finish X travel first, then Y, then eject.
   function automatic logic [2:0] route_port(input logic [FLIT_W-1:0] f);
      if (f[HOPX_LSB +: 4] != 4'd0)
         return f[XDIR_BIT] ? PORT_W : PORT_E;
      else if (f[HOPY_LSB +: 4] != 4'd0)
         return f[YDIR_BIT] ? PORT_S : PORT_N;
      return PORT_L;
   endfunction

   // Flit as it leaves through port p: the hop count of that dimension drops by one.
   function automatic logic [FLIT_W-1:0] hop_dec(input logic [FLIT_W-1:0] f, input logic [2:0] p);
      logic [FLIT_W-1:0] r;
      r = f;
      if (p == PORT_E || p == PORT_W)
         r[HOPX_LSB +: 4] = f[HOPX_LSB +: 4] - 4'd1;
      else if (p == PORT_N || p == PORT_S)
         r[HOPY_LSB +: 4] = f[HOPY_LSB +: 4] - 4'd1;
      return r;
   endfunction

   // (a + k) modulo 5, for walking the five router ports in a ring.
   function automatic logic [2:0] wrap5(input logic [2:0] a, input logic [2:0] k);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, k};
      return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
   endfunction

endpackage

// File: rtl/mesh_router.sv
// One mesh router: five single-flit input buffers (L,N,S,E,W), dimension-order
// route compute, a round-robin arbiter per output and the local eject register.
// Link outputs are combinational from registered state; downstream readiness is
// the neighbour's registered buffer-empty flag, so no buffer frees and refills
// in the same cycle and no combinational path crosses a link.
module mesh_router
   import noc_pkg::*;
#(
   parameter logic [4:0] LINK_MASK = 5'b11111
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             in_valid,
   input  logic [4:0][FLIT_W-1:0] in_flit,
   input  logic [4:0]             down_ready,
   output logic [4:0]             full,
   output logic [4:0]             out_valid,
   output logic [4:0][FLIT_W-1:0] out_flit
);

   logic [4:0][FLIT_W-1:0] buf_reg;
   logic [4:0]             full_reg, full_next;
   logic [4:0][2:0]        ptr_reg, ptr_next;
   logic [4:0][2:0]        route;
   logic [4:0][4:0]        req;
   logic [4:0]             drop, grant_in, win_valid, fire;
   logic [4:0][2:0]        win_idx;
   logic [2:0]             cand;
   logic                   eject_valid_reg;
   logic [FLIT_W-1:0]      eject_reg;

   // Route each buffered flit; routes off the mesh edge are dropped, not requested.
   always_comb begin
      route = '0;
      req   = '0;
      drop  = '0;
      for (int i = 0; i < 5; i++) begin
         route[i] = route_port(buf_reg[i]);
         drop[i]  = full_reg[i] & ~LINK_MASK[route[i]];
         for (int o = 0; o < 5; o++)
            req[i][o] = full_reg[i] & LINK_MASK[o] & (route[i] == 3'(o));
      end
   end

   // Round-robin pick per output starting at its pointer; grant only if downstream can take it.
   always_comb begin
      win_valid = '0;
      win_idx   = '0;
      fire      = '0;
      grant_in  = '0;
      ptr_next  = ptr_reg;
      cand      = '0;
      for (int o = 0; o < 5; o++) begin
         for (int k = 0; k < 5; k++) begin
            cand = wrap5(ptr_reg[o], 3'(k));
            if (!win_valid[o] && req[cand][o]) begin
               win_valid[o] = 1'b1;
               win_idx[o]   = cand;
            end
         end
         fire[o] = win_valid[o] & down_ready[o];
         if (fire[o]) begin
            grant_in[win_idx[o]] = 1'b1;
            ptr_next[o]          = wrap5(win_idx[o], 3'd1);
         end
      end
   end

   // A buffer empties on grant or drop, and fills only if it was empty at cycle start.
   always_comb full_next = (full_reg & ~grant_in & ~drop) | (in_valid & ~full_reg);

   // Buffer, pointer and eject registers; reset discards everything in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_reg         <= '0;
         full_reg        <= '0;
         ptr_reg         <= '0;
         eject_valid_reg <= 1'b0;
         eject_reg       <= '0;
      end else begin
         full_reg        <= full_next;
         ptr_reg         <= ptr_next;
         eject_valid_reg <= fire[PORT_L];
         if (fire[PORT_L])
            eject_reg <= buf_reg[win_idx[PORT_L]];
         for (int i = 0; i < 5; i++)
            if (in_valid[i] && !full_reg[i])
               buf_reg[i] <= in_flit[i];
      end
   end

   // Link outputs carry the winning flit with its hop decremented; L carries the eject register.
   always_comb begin
      full      = full_reg;
      out_valid = fire;
      out_flit  = '0;
      for (int o = 1; o < 5; o++)
         out_flit[o] = hop_dec(buf_reg[win_idx[o]], 3'(o));
      out_valid[PORT_L] = eject_valid_reg;
      out_flit[PORT_L]  = eject_reg;
   end

endmodule

// File: rtl/cardinal_mesh_4x4.sv
// 4x4 mesh of routers joined by single-flit links. Tile (x,y) is index x*4+y;
// north is +y, east is +x. Missing edge links are tied off: never valid, never ready.
module cardinal_mesh_4x4
   import noc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic polarity,
   input  logic NIC_si_00, NIC_si_01, NIC_si_02, NIC_si_03, NIC_si_10, NIC_si_11, NIC_si_12, NIC_si_13,
   input  logic NIC_si_20, NIC_si_21, NIC_si_22, NIC_si_23, NIC_si_30, NIC_si_31, NIC_si_32, NIC_si_33,
   input  logic [63:0] NIC_di_00, NIC_di_01, NIC_di_02, NIC_di_03, NIC_di_10, NIC_di_11, NIC_di_12, NIC_di_13,
   input  logic [63:0] NIC_di_20, NIC_di_21, NIC_di_22, NIC_di_23, NIC_di_30, NIC_di_31, NIC_di_32, NIC_di_33,
   output logic NIC_ri_00, NIC_ri_01, NIC_ri_02, NIC_ri_03, NIC_ri_10, NIC_ri_11, NIC_ri_12, NIC_ri_13,
   output logic NIC_ri_20, NIC_ri_21, NIC_ri_22, NIC_ri_23, NIC_ri_30, NIC_ri_31, NIC_ri_32, NIC_ri_33,
   output logic NIC_so_00, NIC_so_01, NIC_so_02, NIC_so_03, NIC_so_10, NIC_so_11, NIC_so_12, NIC_so_13,
   output logic NIC_so_20, NIC_so_21, NIC_so_22, NIC_so_23, NIC_so_30, NIC_so_31, NIC_so_32, NIC_so_33,
   output logic [63:0] NIC_do_00, NIC_do_01, NIC_do_02, NIC_do_03, NIC_do_10, NIC_do_11, NIC_do_12, NIC_do_13,
   output logic [63:0] NIC_do_20, NIC_do_21, NIC_do_22, NIC_do_23, NIC_do_30, NIC_do_31, NIC_do_32, NIC_do_33,
   input  logic NIC_ro_00, NIC_ro_01, NIC_ro_02, NIC_ro_03, NIC_ro_10, NIC_ro_11, NIC_ro_12, NIC_ro_13,
   input  logic NIC_ro_20, NIC_ro_21, NIC_ro_22, NIC_ro_23, NIC_ro_30, NIC_ro_31, NIC_ro_32, NIC_ro_33
);

   logic [15:0]             si, ro, so, ri;
   logic [15:0][FLIT_W-1:0] di, eject;
   logic [4:0]              r_in_valid   [16];
   logic [4:0][FLIT_W-1:0]  r_in_flit    [16];
   logic [4:0]              r_down_ready [16];
   logic [4:0]              r_full       [16];
   logic [4:0]              r_out_valid  [16];
   logic [4:0][FLIT_W-1:0]  r_out_flit   [16];

   // The polarity input has no function in these routers.
   logic unused_polarity;
   assign unused_polarity = polarity;

   assign si = {NIC_si_33, NIC_si_32, NIC_si_31, NIC_si_30, NIC_si_23, NIC_si_22, NIC_si_21, NIC_si_20,
                NIC_si_13, NIC_si_12, NIC_si_11, NIC_si_10, NIC_si_03, NIC_si_02, NIC_si_01, NIC_si_00};
   assign ro = {NIC_ro_33, NIC_ro_32, NIC_ro_31, NIC_ro_30, NIC_ro_23, NIC_ro_22, NIC_ro_21, NIC_ro_20,
                NIC_ro_13, NIC_ro_12, NIC_ro_11, NIC_ro_10, NIC_ro_03, NIC_ro_02, NIC_ro_01, NIC_ro_00};
   assign di = {NIC_di_33, NIC_di_32, NIC_di_31, NIC_di_30, NIC_di_23, NIC_di_22, NIC_di_21, NIC_di_20,
                NIC_di_13, NIC_di_12, NIC_di_11, NIC_di_10, NIC_di_03, NIC_di_02, NIC_di_01, NIC_di_00};
   assign {NIC_so_33, NIC_so_32, NIC_so_31, NIC_so_30, NIC_so_23, NIC_so_22, NIC_so_21, NIC_so_20,
           NIC_so_13, NIC_so_12, NIC_so_11, NIC_so_10, NIC_so_03, NIC_so_02, NIC_so_01, NIC_so_00} = so;
   assign {NIC_ri_33, NIC_ri_32, NIC_ri_31, NIC_ri_30, NIC_ri_23, NIC_ri_22, NIC_ri_21, NIC_ri_20,
           NIC_ri_13, NIC_ri_12, NIC_ri_11, NIC_ri_10, NIC_ri_03, NIC_ri_02, NIC_ri_01, NIC_ri_00} = ri;
   assign {NIC_do_33, NIC_do_32, NIC_do_31, NIC_do_30, NIC_do_23, NIC_do_22, NIC_do_21, NIC_do_20,
           NIC_do_13, NIC_do_12, NIC_do_11, NIC_do_10, NIC_do_03, NIC_do_02, NIC_do_01, NIC_do_00} = eject;

   for (genvar gx = 0; gx < 4; gx++) begin : g_x
      for (genvar gy = 0; gy < 4; gy++) begin : g_y
         localparam int   T     = gx * 4 + gy;
         localparam logic HAS_N = (gy < 3);
         localparam logic HAS_S = (gy > 0);
         localparam logic HAS_E = (gx < 3);
         localparam logic HAS_W = (gx > 0);
         // Missing neighbours point back at this tile; their valid/ready are masked off.
         localparam int   TN    = HAS_N ? T + 1 : T;
         localparam int   TS    = HAS_S ? T - 1 : T;
         localparam int   TE    = HAS_E ? T + 4 : T;
         localparam int   TW    = HAS_W ? T - 4 : T;

         assign r_in_valid[T] = {HAS_W & r_out_valid[TW][PORT_E], HAS_E & r_out_valid[TE][PORT_W],
                                 HAS_S & r_out_valid[TS][PORT_N], HAS_N & r_out_valid[TN][PORT_S], si[T]};
         assign r_in_flit[T]  = {r_out_flit[TW][PORT_E], r_out_flit[TE][PORT_W],
                                 r_out_flit[TS][PORT_N], r_out_flit[TN][PORT_S], di[T]};
         assign r_down_ready[T] = {HAS_W & ~r_full[TW][PORT_E], HAS_E & ~r_full[TE][PORT_W],
                                   HAS_S & ~r_full[TS][PORT_N], HAS_N & ~r_full[TN][PORT_S], ro[T]};

         assign so[T]    = r_out_valid[T][PORT_L];
         assign eject[T] = r_out_flit[T][PORT_L];
         assign ri[T]    = ~r_full[T][PORT_L];

         mesh_router #(
            .LINK_MASK ({HAS_W, HAS_E, HAS_S, HAS_N, 1'b1})
         ) u_router (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (r_in_valid[T]),
            .in_flit    (r_in_flit[T]),
            .down_ready (r_down_ready[T]),
            .full       (r_full[T]),
            .out_valid  (r_out_valid[T]),
            .out_flit   (r_out_flit[T])
         );
      end
   end

endmodule

// File: tb/tb_cardinal_mesh_4x4.sv
// Directed bench for the 4x4 mesh. Tile (x,y) maps to index x*4+y.
module tb_cardinal_mesh_4x4;

   logic clk = 1'b0;
   logic reset;
   logic polarity;
   logic [15:0]       si, ro, so, ri;
   logic [15:0][63:0] di, dout;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cardinal_mesh_4x4 dut (
      .clk(clk), .reset(reset), .polarity(polarity),
      .NIC_si_00(si[0]),  .NIC_di_00(di[0]),  .NIC_ri_00(ri[0]),  .NIC_so_00(so[0]),  .NIC_do_00(dout[0]),  .NIC_ro_00(ro[0]),
      .NIC_si_01(si[1]),  .NIC_di_01(di[1]),  .NIC_ri_01(ri[1]),  .NIC_so_01(so[1]),  .NIC_do_01(dout[1]),  .NIC_ro_01(ro[1]),
      .NIC_si_02(si[2]),  .NIC_di_02(di[2]),  .NIC_ri_02(ri[2]),  .NIC_so_02(so[2]),  .NIC_do_02(dout[2]),  .NIC_ro_02(ro[2]),
      .NIC_si_03(si[3]),  .NIC_di_03(di[3]),  .NIC_ri_03(ri[3]),  .NIC_so_03(so[3]),  .NIC_do_03(dout[3]),  .NIC_ro_03(ro[3]),
      .NIC_si_10(si[4]),  .NIC_di_10(di[4]),  .NIC_ri_10(ri[4]),  .NIC_so_10(so[4]),  .NIC_do_10(dout[4]),  .NIC_ro_10(ro[4]),
      .NIC_si_11(si[5]),  .NIC_di_11(di[5]),  .NIC_ri_11(ri[5]),  .NIC_so_11(so[5]),  .NIC_do_11(dout[5]),  .NIC_ro_11(ro[5]),
      .NIC_si_12(si[6]),  .NIC_di_12(di[6]),  .NIC_ri_12(ri[6]),  .NIC_so_12(so[6]),  .NIC_do_12(dout[6]),  .NIC_ro_12(ro[6]),
      .NIC_si_13(si[7]),  .NIC_di_13(di[7]),  .NIC_ri_13(ri[7]),  .NIC_so_13(so[7]),  .NIC_do_13(dout[7]),  .NIC_ro_13(ro[7]),
      .NIC_si_20(si[8]),  .NIC_di_20(di[8]),  .NIC_ri_20(ri[8]),  .NIC_so_20(so[8]),  .NIC_do_20(dout[8]),  .NIC_ro_20(ro[8]),
      .NIC_si_21(si[9]),  .NIC_di_21(di[9]),  .NIC_ri_21(ri[9]),  .NIC_so_21(so[9]),  .NIC_do_21(dout[9]),  .NIC_ro_21(ro[9]),
      .NIC_si_22(si[10]), .NIC_di_22(di[10]), .NIC_ri_22(ri[10]), .NIC_so_22(so[10]), .NIC_do_22(dout[10]), .NIC_ro_22(ro[10]),
      .NIC_si_23(si[11]), .NIC_di_23(di[11]), .NIC_ri_23(ri[11]), .NIC_so_23(so[11]), .NIC_do_23(dout[11]), .NIC_ro_23(ro[11]),
      .NIC_si_30(si[12]), .NIC_di_30(di[12]), .NIC_ri_30(ri[12]), .NIC_so_30(so[12]), .NIC_do_30(dout[12]), .NIC_ro_30(ro[12]),
      .NIC_si_31(si[13]), .NIC_di_31(di[13]), .NIC_ri_31(ri[13]), .NIC_so_31(so[13]), .NIC_do_31(dout[13]), .NIC_ro_31(ro[13]),
      .NIC_si_32(si[14]), .NIC_di_32(di[14]), .NIC_ri_32(ri[14]), .NIC_so_32(so[14]), .NIC_do_32(dout[14]), .NIC_ro_32(ro[14]),
      .NIC_si_33(si[15]), .NIC_di_33(di[15]), .NIC_ri_33(ri[15]), .NIC_so_33(so[15]), .NIC_do_33(dout[15]), .NIC_ro_33(ro[15])
   );

   // One table entry: source tile, destination tile (-1 = must be discarded),
   // injected flit and edges from injection to the so pulse.
   typedef struct {
      int          src;
      int          dst;
      logic [63:0] flit;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %h", name, act);
      end
   endtask

   task automatic do_reset();
      si = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int hits, hit_tile, hit_cyc;
      logic [63:0] hit_flit, exp;
      hits = 0; hit_tile = -1; hit_cyc = -1; hit_flit = '0;
      exp = v.flit;
      exp[55:48] = 8'h00;
      ro = '1;
      do_reset();
      @(negedge clk);
      si[v.src] = 1'b1;
      di[v.src] = v.flit;
      @(negedge clk);
      si[v.src] = 1'b0;
      check({v.name, " ri low after inject"}, 64'(ri[v.src]), 64'd0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         for (int t = 0; t < 16; t++) begin
            if (so[t]) begin
               hits++;
               if (hits == 1) begin
                  hit_tile = t; hit_cyc = k; hit_flit = dout[t];
               end
            end
         end
      end
      if (v.dst < 0) begin
         check({v.name, " no delivery"}, 64'(hits), 64'd0);
         check({v.name, " ri back high"}, 64'(ri[v.src]), 64'd1);
      end else begin
         check({v.name, " pulse count"}, 64'(hits), 64'd1);
         check({v.name, " tile"}, 64'(hit_tile), 64'(v.dst));
         check({v.name, " latency"}, 64'(hit_cyc), 64'(v.lat));
         check({v.name, " flit"}, hit_flit, exp);
      end
   endtask

   initial begin
      logic [63:0] got [$];
      int cyc [$];
      int other, w;

      polarity = 1'b0; si = '0; di = '0; ro = '1; reset = 1'b0;

      vecs[0] = '{0,  1,  64'h8001_0000_0000_0001, 2, "00to01"};
      vecs[1] = '{0,  15, 64'h0033_0000_0000_00AA, 7, "00to33"};
      vecs[2] = '{12, 3,  64'h4033_0000_0000_00BB, 7, "30to03"};
      vecs[3] = '{1,  0,  64'h2001_0000_0000_D00A, 2, "01to00"};
      vecs[4] = '{5,  10, 64'h0011_0000_0000_1E11, 3, "11to22"};
      vecs[5] = '{10, 10, 64'h0000_0000_0000_0022, 1, "22local"};
      vecs[6] = '{1,  11, 64'h9F22_0000_0000_5A5A, 5, "01to23rsv"};
      vecs[7] = '{15, 0,  64'h6033_0000_0000_0C0C, 7, "33to00"};
      vecs[8] = '{12, -1, 64'h0010_0000_0000_DEAD, 0, "30eastedge"};
      vecs[9] = '{8,  -1, 64'h2001_0000_0000_BEEF, 0, "20southedge"};

      // Reset state, observed while reset is held.
      repeat (2) @(negedge clk);
      check("reset so", 64'(so), 64'd0);
      check("reset ri", 64'(ri), 64'hFFFF);
      check("reset do zero", 64'(dout == '0), 64'd1);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Backpressure: 10 -> 11 held at the destination NIC.
      ro = 16'hFFDF;
      do_reset();
      @(negedge clk);
      si[4] = 1'b1; di[4] = 64'h0001_0000_0000_B10B;
      @(negedge clk);
      si[4] = 1'b0;
      other = 0;
      repeat (10) begin
         @(negedge clk);
         if (so != '0) other++;
      end
      check("bp so held low", 64'(other), 64'd0);
      check("bp ri_10 back high", 64'(ri[4]), 64'd1);
      ro[5] = 1'b1;
      @(negedge clk);
      check("bp so_11 pulse", 64'(so[5]), 64'd1);
      check("bp do_11", dout[5], 64'h0000_0000_0000_B10B);
      @(negedge clk);
      check("bp so_11 one cycle", 64'(so[5]), 64'd0);

      // Pipelining: two flits 00 -> 33 as fast as ri allows.
      ro = '1;
      do_reset();
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
         for (w = 0; w < 10 && !ri[0]; w++) @(negedge clk);
         check("pipe ri ready", 64'(ri[0]), 64'd1);
         si[0] = 1'b1; di[0] = (n == 0) ? 64'h0033_0000_0000_AA01 : 64'h0033_0000_0000_AA02;
         @(negedge clk);
         si[0] = 1'b0;
      end
      got.delete(); other = 0;
      repeat (20) begin
         @(negedge clk);
         for (int t = 0; t < 16; t++) if (so[t]) begin
            if (t == 15) got.push_back(dout[t]); else other++;
         end
      end
      check("pipe count", 64'(got.size()), 64'd2);
      check("pipe stray", 64'(other), 64'd0);
      if (got.size() == 2) begin
         check("pipe first", got[0], 64'h0000_0000_0000_AA01);
         check("pipe second", got[1], 64'h0000_0000_0000_AA02);
      end

      // Contention: 11 -> 31 and 20 -> 31 meet at the 31 eject port.
      do_reset();
      @(negedge clk);
      si[5] = 1'b1; di[5] = 64'h0020_0000_0000_1131;
      si[8] = 1'b1; di[8] = 64'h0011_0000_0000_2031;
      @(negedge clk);
      si[5] = 1'b0; si[8] = 1'b0;
      got.delete(); cyc.delete(); other = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         for (int t = 0; t < 16; t++) if (so[t]) begin
            if (t == 13) begin got.push_back(dout[t]); cyc.push_back(k); end
            else other++;
         end
      end
      check("cont count", 64'(got.size()), 64'd2);
      check("cont stray", 64'(other), 64'd0);
      if (got.size() == 2) begin
         check("cont first cycle", 64'(cyc[0]), 64'd3);
         check("cont second cycle", 64'(cyc[1]), 64'd4);
         check("cont both payloads", 64'((got[0][47:0] ^ got[1][47:0]) == 48'h3100), 64'd1);
      end

      // Reset mid-flight: flit 00 -> 33 must vanish.
      do_reset();
      @(negedge clk);
      si[0] = 1'b1; di[0] = 64'h0033_0000_0000_00AA;
      @(negedge clk);
      si[0] = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midreset so", 64'(so), 64'd0);
      check("midreset ri", 64'(ri), 64'hFFFF);
      @(negedge clk);
      reset = 1'b1;
      other = 0;
      repeat (12) begin
         @(negedge clk);
         if (so != '0) other++;
      end
      check("midreset no delivery", 64'(other), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
